// File: rtl/fir_coeff_sequencer.sv
// Atomic shadow->active coefficient swap for the 4-tap FIR, qualified by sample_en, then a settle window.
// Optional FIR_COEFF_MUTE_EN: mute covers the swap edge through the last settle cycle; otherwise mute is tied low.
module fir_coeff_sequencer #(
    parameter int                     COEFF_WIDTH   = 16,
    parameter int                     SETTLE_CYCLES = 7,
    parameter logic [COEFF_WIDTH-1:0] RST_B0        = 16'h4000,
    parameter logic [COEFF_WIDTH-1:0] RST_B1        = 16'h0000,
    parameter logic [COEFF_WIDTH-1:0] RST_B2        = 16'h0000,
    parameter logic [COEFF_WIDTH-1:0] RST_B3        = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [1:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   commit,
    input  logic                   sample_en,
    input  logic                   clr_err,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] b3,
    output logic                   busy,
    output logic                   settling,
    output logic                   done,
    output logic [15:0]            swap_count,
    output logic                   err_sticky,
    output logic                   mute
);

    localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [CNTW-1:0]        cnt;
    logic [COEFF_WIDTH-1:0] sh0, sh1, sh2, sh3;
    logic                   swap, fin, wr_ok, err_set;

    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE:    if (commit) state_nxt = PENDING;
            PENDING: if (sample_en) begin
                         swap      = 1'b1;
                         state_nxt = SETTLE;
                     end
            SETTLE:  if (cnt == '0) begin
                         fin       = 1'b1;
                         state_nxt = IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    // Writes are blocked only while a swap is armed, so the committed set cannot change under it.
    assign wr_ok   = wr_en && (state != PENDING);
    assign err_set = (wr_en && (state == PENDING)) || (commit && (state != IDLE));

    assign busy     = (state != IDLE);
    assign settling = (state == SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            err_sticky <= 1'b0;
            swap_count <= 16'd0;
            sh0 <= RST_B0; sh1 <= RST_B1; sh2 <= RST_B2; sh3 <= RST_B3;
            b0  <= RST_B0; b1  <= RST_B1; b2  <= RST_B2; b3  <= RST_B3;
        end else begin
            state <= state_nxt;
            done  <= fin;
            if (swap)
                cnt <= CNT_INIT;
            else if ((state == SETTLE) && (cnt != '0))
                cnt <= cnt - 1'b1;
            if (wr_ok) begin
                case (wr_addr)
                    2'd0:    sh0 <= wr_data;
                    2'd1:    sh1 <= wr_data;
                    2'd2:    sh2 <= wr_data;
                    default: sh3 <= wr_data;
                endcase
            end
            // All four taps load on the same edge so the FIR never sees a mixed set.
            if (swap) begin
                b0 <= sh0; b1 <= sh1; b2 <= sh2; b3 <= sh3;
                swap_count <= swap_count + 16'd1;
            end
            if (err_set)
                err_sticky <= 1'b1;
            else if (clr_err)
                err_sticky <= 1'b0;
        end
    end

`ifdef FIR_COEFF_MUTE_EN
    logic mute_q;
    always_ff @(posedge clk) begin
        if (rst)
            mute_q <= 1'b0;
        else if (swap)
            mute_q <= 1'b1;
        else if (fin)
            mute_q <= 1'b0;
    end
    assign mute = mute_q;
`else
    assign mute = 1'b0;
`endif

endmodule
